// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports (A = CPU, B = debug/DMA),
// their completion pulses, the shared read-data return and the busy flag.
interface dmem_arbiter_if;
   logic        a_req;
   logic [31:0] a_addr;
   logic        a_we;
   logic [31:0] a_wdata;
   logic        a_done;
   logic        a_err;

   logic        b_req;
   logic [31:0] b_addr;
   logic        b_we;
   logic [31:0] b_wdata;
   logic        b_done;
   logic        b_err;

   logic [31:0] rdata;
   logic        busy;

   modport master (
      output a_req, a_addr, a_we, a_wdata,
      output b_req, b_addr, b_we, b_wdata,
      input  a_done, a_err, b_done, b_err, rdata, busy
   );

   modport slave (
      input  a_req, a_addr, a_we, a_wdata,
      input  b_req, b_addr, b_we, b_wdata,
      output a_done, a_err, b_done, b_err, rdata, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between CPU port A and loader port B, decodes the
// global/stack regions into an 11-bit word index and sequences one RAM access per request.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus,
   output logic [10:0]   mem_addr,
   output logic          mem_en,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);
   localparam int unsigned DW   = 32;
   localparam int unsigned IW   = 11;
   localparam int unsigned CW   = 3;
   localparam int unsigned CMAX = (1 << CW) - 1;
   localparam logic [CW-1:0] MAX_WAIT_C = CW'((MAX_WAIT > CMAX) ? CMAX : MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

   state_e          state_q, state_d;
   logic            grant_b_q, grant_b_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            we_q, we_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic            a_done_q, a_done_d;
   logic            b_done_q, b_done_d;
   logic            a_err_q, a_err_d;
   logic            b_err_q, b_err_d;
   logic            busy_q, busy_d;
   logic            rd_pass_q, rd_pass_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic            sel_b;
   logic [DW-1:0]   sel_addr;
   logic            sel_we;
   logic [DW-1:0]   sel_wdata;
   logic [IW:0]     dec;

   // {valid, index}: global maps to the low half, stack to the high half of the RAM
   function automatic logic [IW:0] decode(input logic [DW-1:0] addr);
      logic glob;
      logic stk;
      glob   = (addr[31:12] == 20'h10010);
      stk    = (addr >= 32'h7FFF_EFFC) && (addr <= 32'h7FFF_FFFB);
      decode = {(glob || stk) && (addr[1:0] == 2'b00),
                stk ? IW'(addr[12:2] + 11'd1) : addr[12:2]};
   endfunction

   always_comb begin
      state_d   = state_q;
      grant_b_d = grant_b_q;
      idx_d     = idx_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      wait_d    = wait_q;
      mem_en_d  = 1'b0;
      mem_we_d  = 1'b0;
      a_done_d  = 1'b0;
      b_done_d  = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      rd_pass_d = 1'b0;
      rdata_d   = rdata_q;

      sel_b     = bus.b_req && (!bus.a_req || (wait_q >= MAX_WAIT_C));
      sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
      sel_we    = sel_b ? bus.b_we    : bus.a_we;
      sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;
      dec       = decode(sel_addr);

      // RAM data is only present during the done cycle; keep a copy for afterwards
      if (rd_pass_q) rdata_d = mem_rdata;
      if (!bus.b_req) wait_d = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               grant_b_d = sel_b;
               idx_d     = dec[IW-1:0];
               we_d      = sel_we;
               wdata_d   = sel_wdata;
               if (sel_b)                             wait_d = '0;
               else if (bus.b_req && (wait_q != '1)) wait_d = wait_q + CW'(1);
               if (dec[IW]) begin
                  state_d  = ACCESS;
                  mem_en_d = 1'b1;
                  mem_we_d = sel_we;
               end else begin
                  state_d  = ERR;
                  a_done_d = !sel_b;
                  b_done_d = sel_b;
                  a_err_d  = !sel_b;
                  b_err_d  = sel_b;
               end
            end
         end
         ACCESS: begin
            state_d   = RESP;
            a_done_d  = !grant_b_q;
            b_done_d  = grant_b_q;
            rd_pass_d = !we_q;
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_b_q <= 1'b0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wait_q    <= '0;
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         a_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         busy_q    <= 1'b0;
         rd_pass_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         grant_b_q <= grant_b_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         wait_q    <= wait_d;
         mem_en_q  <= mem_en_d;
         mem_we_q  <= mem_we_d;
         a_done_q  <= a_done_d;
         b_done_q  <= b_done_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         busy_q    <= busy_d;
         rd_pass_q <= rd_pass_d;
         rdata_q   <= rdata_d;
      end
   end

   assign mem_addr   = idx_q;
   assign mem_wdata  = wdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign bus.a_done = a_done_q;
   assign bus.b_done = b_done_q;
   assign bus.a_err  = a_err_q;
   assign bus.b_err  = b_err_q;
   assign bus.busy   = busy_q;
   assign bus.rdata  = rd_pass_q ? mem_rdata : rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and randomized transactions against an address-map
// and memory-content reference model, plus fairness, ordering and mid-access reset checks.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] mem_addr;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM macro: synchronous read, preloaded from seed_mem while preload is high
   logic [31:0] ram      [2048];
   logic [31:0] seed_mem [2048];
   logic [31:0] ref_mem  [2048];
   logic        preload;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) ram[i] <= seed_mem[i];
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Address map from the region bounds, using plain arithmetic on byte offsets
   function automatic bit ref_decode(input logic [31:0] addr, output int idx);
      longint unsigned a;
      a   = longint'(addr);
      idx = 0;
      if (a % 4 != 0) return 1'b0;
      if (a >= 64'h1001_0000 && a <= 64'h1001_0FFF) begin
         idx = int'((a - 64'h1001_0000) / 4);
         return 1'b1;
      end
      if (a >= 64'h7FFF_EFFC && a <= 64'h7FFF_FFFB) begin
         idx = 1024 + int'((a - 64'h7FFF_EFFC) / 4);
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive(input bit pb, input bit req, input logic [31:0] addr,
                        input bit we, input logic [31:0] wd);
      if (pb) begin
         bus.b_req = req; bus.b_addr = addr; bus.b_we = we; bus.b_wdata = wd;
      end else begin
         bus.a_req = req; bus.a_addr = addr; bus.a_we = we; bus.a_wdata = wd;
      end
   endtask

   // One isolated transaction on port pb, checked cycle by cycle
   task automatic txn(input bit pb, input logic [31:0] addr, input bit we,
                      input logic [31:0] wd, input string tag);
      int   idx;
      bit   ok;
      logic done_w, err_w, other_w;
      ok = ref_decode(addr, idx);
      drive(pb, 1'b1, addr, we, wd);
      step();
      done_w = pb ? bus.b_done : bus.a_done;
      err_w  = pb ? bus.b_err  : bus.a_err;
      if (ok) begin
         check({tag, " mem_en"},   32'(mem_en), 32'd1);
         check({tag, " mem_addr"}, 32'(mem_addr), 32'(idx));
         check({tag, " mem_we"},   32'(mem_we), 32'(we));
         if (we) check({tag, " mem_wdata"}, mem_wdata, wd);
         check({tag, " early_done"}, 32'(done_w), 32'd0);
         step();
         done_w  = pb ? bus.b_done : bus.a_done;
         err_w   = pb ? bus.b_err  : bus.a_err;
         other_w = pb ? bus.a_done : bus.b_done;
         check({tag, " done"},  32'(done_w), 32'd1);
         check({tag, " err"},   32'(err_w), 32'd0);
         check({tag, " other"}, 32'(other_w), 32'd0);
         check({tag, " en_off"}, 32'(mem_en), 32'd0);
         if (!we) check({tag, " rdata"}, bus.rdata, ref_mem[idx]);
         else     ref_mem[idx] = wd;
         drive(pb, 1'b0, addr, we, wd);
         step();
         check({tag, " idle"}, 32'({bus.busy, bus.a_done, bus.b_done}), 32'd0);
      end else begin
         check({tag, " err_done"}, 32'(done_w), 32'd1);
         check({tag, " err_flag"}, 32'(err_w), 32'd1);
         check({tag, " err_en"},   32'(mem_en), 32'd0);
         drive(pb, 1'b0, addr, we, wd);
         step();
         check({tag, " err_after"}, 32'({mem_en, bus.a_done, bus.b_done}), 32'd0);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 3))
         0:       a = 32'h1001_0000 + 32'(4 * $urandom_range(0, 1023));
         1:       a = 32'h7FFF_EFFC + 32'(4 * $urandom_range(0, 1023));
         2:       a = 32'h1001_0000 + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
         default: a = $urandom;
      endcase
      return a;
   endfunction

   initial begin
      int grants;
      int last;
      int ta;
      int tb;
      int idx;
      bit ok;
      logic [31:0] old;

      rst_n   = 1'b0;
      preload = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 2048; i++) begin
         seed_mem[i] = $urandom;
         ref_mem[i]  = seed_mem[i];
      end
      seed_mem[1] = 32'hDEAD_BEEF;
      ref_mem[1]  = 32'hDEAD_BEEF;
      #1;
      check("rst_en",    32'({mem_en, mem_we}), 32'd0);
      check("rst_done",  32'({bus.a_done, bus.a_err, bus.b_done, bus.b_err, bus.busy}), 32'd0);
      check("rst_addr",  32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      step();
      step();
      preload = 1'b0;
      rst_n   = 1'b1;
      step();

      txn(1'b0, 32'h1001_0004, 1'b0, '0, "a_rd_beef");
      txn(1'b1, 32'h7FFF_EFFC, 1'b1, 32'h1234_5678, "b_wr_lo");
      txn(1'b1, 32'h7FFF_FFF8, 1'b1, 32'h8765_4321, "b_wr_hi");
      txn(1'b0, 32'h1001_1000, 1'b0, '0, "a_err_range");
      txn(1'b1, 32'h1001_0002, 1'b0, '0, "b_err_align");
      txn(1'b0, 32'h7FFF_FFFC, 1'b1, 32'h1, "a_err_stack");
      txn(1'b0, 32'h7FFF_EFF8, 1'b0, '0, "a_err_below");
      txn(1'b0, 32'h7FFF_EFFC, 1'b0, '0, "a_rdback_lo");
      txn(1'b1, 32'h7FFF_FFF8, 1'b0, '0, "b_rdback_hi");
      txn(1'b1, 32'h1001_0FFC, 1'b1, 32'hA5A5_5A5A, "b_wr_gtop");
      txn(1'b0, 32'h1001_0FFC, 1'b0, '0, "a_rd_gtop");

      // Both ports hammering: four A grants then one B grant, done every 3 cycles
      drive(1'b0, 1'b1, 32'h1001_0008, 1'b0, '0);
      drive(1'b1, 1'b1, 32'h7FFF_F000, 1'b0, '0);
      grants = 0;
      last   = -1;
      for (int c = 0; c < 80 && grants < 15; c++) begin
         step();
         if (bus.a_done || bus.b_done) begin
            check("fair_grant_b", 32'(bus.b_done), 32'((grants % 5 == 4) ? 1 : 0));
            check("fair_excl", 32'(bus.a_done & bus.b_done), 32'd0);
            if (last >= 0) check("fair_gap", 32'(c - last), 32'd3);
            last = c;
            grants++;
         end
      end
      check("fair_count", 32'(grants), 32'd15);
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      step();
      step();

      // Simultaneous single requests: A first, B at the next IDLE sample
      drive(1'b0, 1'b1, 32'h1001_0010, 1'b0, '0);
      drive(1'b1, 1'b1, 32'h7FFF_F100, 1'b0, '0);
      ta = -100;
      tb = -100;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.a_done) begin
            ta = c;
            check("sim_a_rdata", bus.rdata, ref_mem[4]);
            drive(1'b0, 1'b0, '0, 1'b0, '0);
         end
         if (bus.b_done) begin
            tb = c;
            ok = ref_decode(32'h7FFF_F100, idx);
            check("sim_b_rdata", bus.rdata, ref_mem[idx]);
            drive(1'b1, 1'b0, '0, 1'b0, '0);
         end
      end
      check("sim_a_time", 32'(ta), 32'd1);
      check("sim_b_time", 32'(tb), 32'd4);

      // Reset during the RAM cycle of a write: nothing completes, nothing is written
      old = ref_mem[8];
      drive(1'b0, 1'b1, 32'h1001_0020, 1'b1, 32'hCAFE_F00D);
      step();
      check("rstw_en", 32'({mem_en, mem_we}), 32'd3);
      rst_n = 1'b0;
      #1;
      check("rstw_en_off", 32'({mem_en, mem_we}), 32'd0);
      check("rstw_outs", 32'({bus.a_done, bus.a_err, bus.b_done, bus.b_err, bus.busy}), 32'd0);
      check("rstw_addr", 32'(mem_addr), 32'd0);
      check("rstw_wdata", mem_wdata, 32'd0);
      check("rstw_rdata", bus.rdata, 32'd0);
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      step();
      check("rstw_nodone", 32'(bus.a_done), 32'd0);
      rst_n = 1'b1;
      step();
      check("rstw_kept", ref_mem[8], old);
      txn(1'b0, 32'h1001_0020, 1'b0, '0, "rstw_rdback");

      for (int n = 0; n < 40; n++) begin
         txn(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), $urandom,
             $sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the SoC's 2048-word data memory. It shares the single-port, synchronous-read data RAM between the CPU load/store port (port A) and a debug/DMA loader port (port B). Each request is decoded against the global and stack regions, sequenced into one RAM access, and answered with a one-cycle `done` (plus `err`) to the granted requester. It sits between the MIPS32 datapath's memory stage and the RAM macro, and replaces direct decoder-to-RAM wiring.

## Interface
- `MAX_WAIT`, default 4: consecutive cycles port B may be denied before it overrides port A's priority.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_req` / `b_req` in 1: access request; held high with stable addr/we/wdata until `done` is seen.
- `a_addr` / `b_addr` in 32: virtual byte address.
- `a_we` / `b_we` in 1: 1 = write, 0 = read.
- `a_wdata` / `b_wdata` in 32: write data.
- `a_done` / `b_done` out 1: one-cycle completion pulse.
- `a_err` / `b_err` out 1: valid only with `done`; 1 = invalid or misaligned address, no RAM access made.
- `rdata` out 32: read data, valid the cycle `*_done` is high for a read; otherwise holds its last value.
- `mem_addr` out 11: RAM word index.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable, qualified by `mem_en`.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, registered by the RAM one cycle after `mem_en`.
- `busy` out 1: state is not IDLE.

## Operation
- Address map:
  - Global region 0x10010000–0x10010FFF: index = addr[12:2], giving 0x000–0x3FF.
  - Stack region 0x7FFFEFFC–0x7FFFFFFB: index = addr[12:2] + 1 (11-bit), giving 0x400–0x7FF.
  - Any other address, or addr[1:0] ≠ 0, is an error.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE, with no request: stay in IDLE.
- IDLE, with any request: pick the winner, then latch grant id, index, we and wdata.
  - Valid address: go to ACCESS.
  - Invalid address: go to ERR.
- Winner selection:
  - Port A wins by default.
  - Port B wins if only B requests, or if `wait_cnt` ≥ MAX_WAIT.
- ACCESS: `mem_en` = 1, `mem_we` = latched we, `mem_addr` and `mem_wdata` driven from the latches. Go to RESP.
- RESP: winner's `done` = 1, `err` = 0; `rdata` loads `mem_rdata` on reads only. Go to IDLE.
- ERR: winner's `done` = 1, `err` = 1; `mem_en` stays 0 and `rdata` is unchanged. Go to IDLE.
- `wait_cnt` (3-bit, saturating):
  - Increments each IDLE cycle in which B requests and A wins.
  - Clears when B is granted, or when `b_req` = 0.
- Requests are sampled only in IDLE. A request that drops mid-transaction still completes, and `done` is still pulsed.
- `mem_en`, `mem_we` and `done` are all registered (state-decoded from flops).

## Timing
- Reset values: state IDLE; `mem_en`, `mem_we`, `*_done`, `*_err`, `busy` = 0; `mem_addr` = 0; `mem_wdata` = 0; `rdata` = 0; `wait_cnt` = 0.
- Request seen in IDLE at edge k:
  - `mem_en` is high during cycle k+1.
  - `done` is high during cycle k+2.
  - The next IDLE sample is at edge k+3.
- Error latency: `done` and `err` are high during cycle k+1; the next sample is at edge k+2.
- Throughput: one access per 3 cycles; one error per 2 cycles.
- Requester rule: drop `req`, or present a new request, on the edge after `done`. A still-high `req` at the next IDLE sample is treated as a new request.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. No `done` is issued, and any pending write is not performed unless `mem_en` had already been sampled by the RAM.

## Test plan
- A reads 0x10010004 with RAM word 1 = 0xDEADBEEF: `mem_addr` = 0x001 and `mem_en` = 1 at k+1; `a_done` = 1, `a_err` = 0, `rdata` = 0xDEADBEEF at k+2.
- B writes 0x12345678 to 0x7FFFEFFC: `mem_addr` = 0x400, `mem_we` = 1, `mem_wdata` = 0x12345678 at k+1; `b_done` = 1 at k+2. Repeat at 0x7FFFFFF8: `mem_addr` = 0x7FF.
- Errors, with `mem_en` never high:
  - A accesses 0x10011000: `a_done` = 1, `a_err` = 1 at k+1.
  - B accesses 0x10010002: `b_done` = 1, `b_err` = 1 at k+1.
  - A accesses 0x7FFFFFFC: `a_done` = 1, `a_err` = 1 at k+1.
- A and B both request continuously, MAX_WAIT = 4: A is granted 4 consecutive times, B on the 5th; the pattern repeats; B is never starved.
- Simultaneous single requests: A granted first, B granted at the next IDLE; `done` pulses exactly 3 cycles apart.
- `rst_n` pulled low during ACCESS of a write: outputs return to reset values immediately; no `done`; after release, a fresh A read completes normally.
